// File: rtl/warp_scheduler.sv
// -----------------------------------------------------------------------------
// warp_scheduler
// Time-slices a shared in-order pipeline between two warps. A running warp
// yields when it finishes, when it stalls on memory, or when its quantum of
// retired instructions (counted on UPDATE) expires, provided the other warp
// can run. A switch takes two held cycles: SW_SAVE (context store saves the
// outgoing warp on switch_pulse) then SW_LOAD (warp_select flips).
//
// Ports
//   clk            sole clock, rising edge
//   reset          synchronous, active-high
//   start_1/2      per-warp launch pulses (honoured in IDLE and RUN)
//   warp_done_1/2  per-warp completion flags
//   core_state     shared pipeline state (WAIT=100, UPDATE=110 used here)
//   lsu_waiting    running warp stalled on an outstanding memory access
//   warp_select    0 = warp 1, 1 = warp 2
//   switch_pulse   one-cycle save strobe (SW_SAVE)
//   pipeline_hold  freezes the shared pipeline
//   active_1/2     warp launched and not finished
//   all_done       every launched warp finished
//   switch_count   completed switches, saturating at 255
// All outputs are registered.
// -----------------------------------------------------------------------------
module warp_scheduler #(
  parameter int unsigned QUANTUM = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_1,
  input  logic       start_2,
  input  logic       warp_done_1,
  input  logic       warp_done_2,
  input  logic [2:0] core_state,
  input  logic       lsu_waiting,
  output logic       warp_select,
  output logic       switch_pulse,
  output logic       pipeline_hold,
  output logic       active_1,
  output logic       active_2,
  output logic       all_done,
  output logic [7:0] switch_count
);

  localparam logic [2:0] CS_WAIT    = 3'b100;
  localparam logic [2:0] CS_UPDATE  = 3'b110;
  localparam logic [7:0] QUANT_LAST = 8'(QUANTUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_SW_SAVE = 3'd2,
    ST_SW_LOAD = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic [7:0] quant_q, quant_d;
  logic [7:0] swcnt_q, swcnt_d;
  logic [1:0] launched_q, launched_d;
  logic [1:0] finished_q, finished_d;
  logic       pulse_q, hold_q, all_done_q;
  logic [1:0] active_q;

  // Bit 0 is warp 1, bit 1 is warp 2, so sel_q indexes these vectors directly.
  logic [1:0] start_v, done_now, ready_now;
  logic       cur_gone, oth_ok, stall, at_update, expire;

  // Next-state logic: flags, FSM transitions, quantum and switch counters.
  always_comb begin
    start_v    = {start_2, start_1};
    // A done flag arriving this cycle already counts, so no decision is made
    // on stale readiness (never switch into a warp finishing right now).
    done_now   = {warp_done_2, warp_done_1} & launched_q;
    ready_now  = launched_q & ~finished_q & ~done_now;
    cur_gone   = ~ready_now[sel_q];
    oth_ok     = ready_now[~sel_q];
    stall      = (core_state == CS_WAIT) && lsu_waiting;
    at_update  = (core_state == CS_UPDATE);
    expire     = at_update && (quant_q == QUANT_LAST);

    state_d    = state_q;
    sel_d      = sel_q;
    quant_d    = quant_q;
    swcnt_d    = swcnt_q;
    launched_d = launched_q;
    finished_d = finished_q | done_now;

    case (state_q)
      ST_IDLE: begin
        if (start_v != 2'b00) begin
          launched_d = launched_q | start_v;
          state_d    = ST_RUN;
          sel_d      = ~start_1;  // warp 1 wins a simultaneous launch
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_RUN: begin
        launched_d = launched_q | start_v;
        // Expiry without a switch starts a fresh quantum for the same warp.
        if (at_update) begin
          quant_d = expire ? 8'd0 : (quant_q + 8'd1);
        end else begin
          quant_d = quant_q;
        end
        // One switch regardless of how many causes coincide.
        if (oth_ok && (cur_gone || stall || expire)) begin
          state_d = ST_SW_SAVE;
        end else if (cur_gone && (ready_now == 2'b00)) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SW_SAVE: begin
        state_d = ST_SW_LOAD;
        sel_d   = ~sel_q;
        quant_d = 8'd0;
        swcnt_d = (swcnt_q == 8'hFF) ? swcnt_q : (swcnt_q + 8'd1);
      end
      ST_SW_LOAD: begin
        state_d = ST_RUN;
      end
      ST_FINISH: begin
        state_d = ST_FINISH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      quant_q    <= 8'd0;
      swcnt_q    <= 8'd0;
      launched_q <= 2'b00;
      finished_q <= 2'b00;
      pulse_q    <= 1'b0;
      hold_q     <= 1'b1;
      all_done_q <= 1'b0;
      active_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      quant_q    <= quant_d;
      swcnt_q    <= swcnt_d;
      launched_q <= launched_d;
      finished_q <= finished_d;
      pulse_q    <= (state_d == ST_SW_SAVE);
      hold_q     <= (state_d != ST_RUN);
      all_done_q <= (state_d == ST_FINISH);
      active_q   <= launched_d & ~finished_d;
    end
  end

  assign warp_select   = sel_q;
  assign switch_pulse  = pulse_q;
  assign pipeline_hold = hold_q;
  assign active_1      = active_q[0];
  assign active_2      = active_q[1];
  assign all_done      = all_done_q;
  assign switch_count  = swcnt_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// -----------------------------------------------------------------------------
// tb_warp_scheduler
// Two schedulers (QUANTUM=4 and QUANTUM=1) share one stimulus stream. Each is
// compared every cycle against a behavioural model; directed tables and
// hand-written sequences add hand-derived expectations for the corner cases.
// -----------------------------------------------------------------------------
module tb_warp_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start_1, start_2, warp_done_1, warp_done_2, lsu_waiting;
  logic [2:0] core_state;

  logic       sel4, pulse4, hold4, a1_4, a2_4, done4;
  logic [7:0] cnt4;
  logic       sel1, pulse1, hold1, a1_1, a2_1, done1;
  logic [7:0] cnt1;

  int total = 0;
  int bad   = 0;

  warp_scheduler #(.QUANTUM(4)) dut4 (
    .clk(clk), .reset(reset), .start_1(start_1), .start_2(start_2),
    .warp_done_1(warp_done_1), .warp_done_2(warp_done_2),
    .core_state(core_state), .lsu_waiting(lsu_waiting),
    .warp_select(sel4), .switch_pulse(pulse4), .pipeline_hold(hold4),
    .active_1(a1_4), .active_2(a2_4), .all_done(done4), .switch_count(cnt4)
  );

  warp_scheduler #(.QUANTUM(1)) dut1 (
    .clk(clk), .reset(reset), .start_1(start_1), .start_2(start_2),
    .warp_done_1(warp_done_1), .warp_done_2(warp_done_2),
    .core_state(core_state), .lsu_waiting(lsu_waiting),
    .warp_select(sel1), .switch_pulse(pulse1), .pipeline_hold(hold1),
    .active_1(a1_1), .active_2(a2_1), .all_done(done1), .switch_count(cnt1)
  );

  // Behavioural model: phase 0 = not started, 1 = running, 2 = all finished.
  // sw_left counts the held cycles still to go in a switch (2 then 1).
  typedef struct packed {
    int       phase;
    int       sw_left;
    bit       sel;
    int       quota;
    int       swc;
    bit [1:0] launched;
    bit [1:0] finished;
  } model_t;

  model_t m4, m1;

  function automatic model_t step(model_t m, int q);
    model_t   n;
    bit [1:0] st, done_now, ready_now;
    bit       cur_gone, other_ok, expire;
    n = m;
    if (reset) begin
      n = '0;
      return n;
    end
    st        = {start_2, start_1};
    done_now  = {warp_done_2, warp_done_1} & m.launched;
    ready_now = m.launched & ~m.finished & ~done_now;
    n.finished = m.finished | done_now;
    if (m.phase == 0 || (m.phase == 1 && m.sw_left == 0))
      n.launched = m.launched | st;
    if (m.phase == 0) begin
      if (st != 2'b00) begin
        n.phase = 1;
        n.sel   = !start_1;
      end
    end else if (m.phase == 1 && m.sw_left == 2) begin
      n.sw_left = 1;
      n.sel     = !m.sel;
      n.quota   = 0;
      if (m.swc < 255) n.swc = m.swc + 1;
    end else if (m.phase == 1 && m.sw_left == 1) begin
      n.sw_left = 0;
    end else if (m.phase == 1) begin
      cur_gone = !ready_now[m.sel];
      other_ok = ready_now[!m.sel];
      expire   = 1'b0;
      if (core_state == 3'b110) begin
        if (m.quota + 1 == q) begin
          expire  = 1'b1;
          n.quota = 0;
        end else begin
          n.quota = m.quota + 1;
        end
      end
      if (other_ok && (cur_gone || (core_state == 3'b100 && lsu_waiting) || expire))
        n.sw_left = 2;
      else if (cur_gone)
        n.phase = 2;
    end
    return n;
  endfunction

  task automatic cmp(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_model(input string tag, input model_t m, input logic sel,
                             input logic pulse, input logic hold, input logic a1,
                             input logic a2, input logic ad, input logic [7:0] cnt);
    cmp({tag, ".sel"},      int'(sel),   int'(m.sel));
    cmp({tag, ".pulse"},    int'(pulse), (m.sw_left == 2) ? 1 : 0);
    cmp({tag, ".hold"},     int'(hold),  (m.phase != 1 || m.sw_left != 0) ? 1 : 0);
    cmp({tag, ".active1"},  int'(a1),    (m.launched[0] && !m.finished[0]) ? 1 : 0);
    cmp({tag, ".active2"},  int'(a2),    (m.launched[1] && !m.finished[1]) ? 1 : 0);
    cmp({tag, ".all_done"}, int'(ad),    (m.phase == 2) ? 1 : 0);
    cmp({tag, ".swcount"},  int'(cnt),   m.swc);
  endtask

  task automatic set_in(input bit r, input bit s1, input bit s2, input bit d1,
                        input bit d2, input logic [2:0] cs, input bit l);
    reset = r; start_1 = s1; start_2 = s2; warp_done_1 = d1; warp_done_2 = d2;
    core_state = cs; lsu_waiting = l;
  endtask

  task automatic tick();
    @(posedge clk);
    m4 = step(m4, 4);
    m1 = step(m1, 1);
    #1;
    check_model("q4", m4, sel4, pulse4, hold4, a1_4, a2_4, done4, cnt4);
    check_model("q1", m1, sel1, pulse1, hold1, a1_1, a2_1, done1, cnt1);
  endtask

  typedef struct packed {
    bit       rst, s1, s2, d1, d2;
    bit [2:0] core;
    bit       lsu;
    bit       e_sel, e_pulse, e_hold, e_done;
    bit [7:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit s1, bit s2, bit d1, bit d2, bit [2:0] c,
                              bit l, bit es, bit ep, bit eh, bit ed, bit [7:0] ec);
    vec_t v;
    v = {r, s1, s2, d1, d2, c, l, es, ep, eh, ed, ec};
    return v;
  endfunction

  vec_t vecs[25];

  initial begin
    int pulses4, pulses1, toggles;
    logic prev_sel;

    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    m4 = '0;
    m1 = '0;

    // QUANTUM=4 expectations: quantum switch, memory-stall switch, no switch
    // toward a finished warp, FINISH stickiness, then single-warp run.
    vecs[0]  = mk(1,0,0,0,0,3'd0,0, 0,0,1,0,8'd0);
    vecs[1]  = mk(0,1,1,0,0,3'd0,0, 0,0,0,0,8'd0);
    vecs[2]  = mk(0,0,0,0,0,3'd6,0, 0,0,0,0,8'd0);
    vecs[3]  = mk(0,0,0,0,0,3'd6,0, 0,0,0,0,8'd0);
    vecs[4]  = mk(0,0,0,0,0,3'd6,0, 0,0,0,0,8'd0);
    vecs[5]  = mk(0,0,0,0,0,3'd6,0, 0,1,1,0,8'd0);
    vecs[6]  = mk(0,0,0,0,0,3'd1,0, 1,0,1,0,8'd1);
    vecs[7]  = mk(0,0,0,0,0,3'd1,0, 1,0,0,0,8'd1);
    vecs[8]  = mk(0,0,0,0,0,3'd1,0, 1,0,0,0,8'd1);
    vecs[9]  = mk(0,0,0,0,0,3'd4,1, 1,1,1,0,8'd1);
    vecs[10] = mk(0,0,0,0,0,3'd1,0, 0,0,1,0,8'd2);
    vecs[11] = mk(0,0,0,0,0,3'd1,0, 0,0,0,0,8'd2);
    vecs[12] = mk(0,0,0,0,1,3'd1,0, 0,0,0,0,8'd2);
    vecs[13] = mk(0,0,0,0,0,3'd4,1, 0,0,0,0,8'd2);
    vecs[14] = mk(0,0,0,0,0,3'd6,0, 0,0,0,0,8'd2);
    vecs[15] = mk(0,0,0,1,0,3'd1,0, 0,0,1,1,8'd2);
    vecs[16] = mk(0,1,1,0,0,3'd0,0, 0,0,1,1,8'd2);
    vecs[17] = mk(1,0,0,0,0,3'd0,0, 0,0,1,0,8'd0);
    vecs[18] = mk(0,1,0,0,0,3'd0,0, 0,0,0,0,8'd0);
    for (int i = 19; i < 24; i++)
      vecs[i] = mk(0,0,0,0,0,3'd6,0, 0,0,0,0,8'd0);
    vecs[24] = mk(0,0,0,1,0,3'd1,0, 0,0,1,1,8'd0);

    for (int i = 0; i < 25; i++) begin
      set_in(vecs[i].rst, vecs[i].s1, vecs[i].s2, vecs[i].d1, vecs[i].d2,
             vecs[i].core, vecs[i].lsu);
      tick();
      cmp($sformatf("vec%0d.sel", i),      int'(sel4),   int'(vecs[i].e_sel));
      cmp($sformatf("vec%0d.pulse", i),    int'(pulse4), int'(vecs[i].e_pulse));
      cmp($sformatf("vec%0d.hold", i),     int'(hold4),  int'(vecs[i].e_hold));
      cmp($sformatf("vec%0d.all_done", i), int'(done4),  int'(vecs[i].e_done));
      cmp($sformatf("vec%0d.swcount", i),  int'(cnt4),   int'(vecs[i].e_cnt));
    end

    // Coinciding causes (finish + stall, finish + UPDATE at quantum for Q=1)
    // must yield exactly one switch.
    for (int v = 0; v < 2; v++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0); tick();
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0); tick();
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (v == 0) ? 3'd4 : 3'd6, 1'b1); tick();
      pulses4 = 0;
      pulses1 = 0;
      for (int c = 0; c < 6; c++) begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (c % 2 == 0) ? 3'd1 : 3'd6, 1'b0);
        pulses4 += int'(pulse4);
        pulses1 += int'(pulse1);
        tick();
      end
      cmp($sformatf("multi%0d.pulses_q4", v), pulses4, 1);
      cmp($sformatf("multi%0d.pulses_q1", v), pulses1, 1);
      cmp($sformatf("multi%0d.swcount_q4", v), int'(cnt4), 1);
      cmp($sformatf("multi%0d.swcount_q1", v), int'(cnt1), 1);
      cmp($sformatf("multi%0d.sel_q4", v), int'(sel4), 1);
    end

    // Reset while in SW_SAVE: back to IDLE, no SW_LOAD completes.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0); tick();
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0); tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1); tick();
    cmp("rst_save.in_save", int'(pulse4), 1);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0); tick();
    cmp("rst_save.sel", int'(sel4), 0);
    cmp("rst_save.hold", int'(hold4), 1);
    cmp("rst_save.pulse", int'(pulse4), 0);
    cmp("rst_save.swcount", int'(cnt4), 0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0); tick();
    cmp("rst_save.idle_hold", int'(hold4), 1);
    cmp("rst_save.idle_swcount", int'(cnt4), 0);

    // QUANTUM=1 saturation: a switch at every UPDATE, select keeps toggling.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0); tick();
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0); tick();
    toggles  = 0;
    prev_sel = sel1;
    for (int c = 0; c < 960; c++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0);
      tick();
      if (sel1 !== prev_sel) toggles++;
      prev_sel = sel1;
    end
    cmp("sat.swcount_q1", int'(cnt1), 255);
    cmp("sat.toggles_ge_300", (toggles >= 300) ? 1 : 0, 1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      set_in(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
